// File: rtl/ravenna.sv
// rtl/ravenna.sv - housekeeping SPI slave with register file and flash pass-through
//
// Ports:
//   XCLK, resetn                 system clock, asynchronous active-low reset
//   SCK, CSB, SDI                housekeeping SPI inputs (mode 0, MSB first)
//   SDO, sdo_enb                 SPI data out and its active-low driver enable
//   core_flash_csb/clk/io0       CPU flash-controller signals
//   flash_csb/clk/io0, flash_io1 external SPI flash pins
//   cpu_resetn                   CPU reset, active-low
module ravenna #(
  parameter logic [11:0] MFGR_ID  = 12'h456,
  parameter logic [7:0]  PROD_ID  = 8'h03,
  parameter logic [3:0]  MASK_REV = 4'h0
) (
  input  logic XCLK,
  input  logic resetn,
  input  logic SCK,
  input  logic CSB,
  input  logic SDI,
  output logic SDO,
  output logic sdo_enb,
  input  logic core_flash_csb,
  input  logic core_flash_clk,
  input  logic core_flash_io0,
  output logic flash_csb,
  output logic flash_clk,
  output logic flash_io0,
  input  logic flash_io1,
  output logic cpu_resetn
);

  typedef enum logic [2:0] {COMMAND, ADDRESS, DATA, PASSTHRU, IGNORE} state_t;

  state_t state, state_next;

  logic [1:0] sck_sync, csb_sync, sdi_sync;
  logic       sck_prev;
  logic       sck_s, csb_s, sdi_s;
  logic       armed;
  logic       idle, sck_rise, sck_fall, byte_done, pass;
  logic [2:0] bit_cnt;
  logic [7:0] shift_in, shift_out, addr, addr_next, byte_in;
  logic       rd_mode, wr_mode, cpu_reset_bit, sdo_r;

  // CSB synchronizer resets low so a CSB still held low after reset is not
  // mistaken for an idle bus; armed is only set by a real synchronized high.
  always_ff @(posedge XCLK or negedge resetn) begin
    if (!resetn) begin
      sck_sync <= 2'b00;
      csb_sync <= 2'b00;
      sdi_sync <= 2'b00;
      sck_prev <= 1'b0;
    end else begin
      sck_sync <= {sck_sync[0], SCK};
      csb_sync <= {csb_sync[0], CSB};
      sdi_sync <= {sdi_sync[0], SDI};
      sck_prev <= sck_sync[1];
    end
  end

  assign sck_s     = sck_sync[1];
  assign csb_s     = csb_sync[1];
  assign sdi_s     = sdi_sync[1];
  assign idle      = csb_s | ~armed;
  assign sck_rise  = sck_s & ~sck_prev & ~idle;
  assign sck_fall  = ~sck_s & sck_prev & ~idle;
  assign byte_in   = {shift_in[6:0], sdi_s};
  assign byte_done = sck_rise && (bit_cnt == 3'd7);
  assign addr_next = addr + 8'd1;
  assign pass      = (state == PASSTHRU);

  function automatic logic [7:0] reg_read(input logic [7:0] a, input logic crst);
    case (a)
      8'h01:   reg_read = {4'h0, MFGR_ID[11:8]};
      8'h02:   reg_read = MFGR_ID[7:0];
      8'h03:   reg_read = PROD_ID;
      8'h04:   reg_read = {4'h0, MASK_REV};
      8'h07:   reg_read = {7'h00, crst};
      default: reg_read = 8'h00;
    endcase
  endfunction

  always_ff @(posedge XCLK or negedge resetn) begin
    if (!resetn) state <= COMMAND;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (idle) begin
      state_next = COMMAND;
    end else if (byte_done) begin
      case (state)
        COMMAND: begin
          case (byte_in)
            8'h80, 8'h40, 8'hC0: state_next = ADDRESS;
            8'hC4:               state_next = PASSTHRU;
            default:             state_next = IGNORE;
          endcase
        end
        ADDRESS: state_next = DATA;
        default: state_next = state;
      endcase
    end
  end

  always_ff @(posedge XCLK or negedge resetn) begin
    if (!resetn) begin
      armed         <= 1'b0;
      bit_cnt       <= 3'd0;
      shift_in      <= 8'h00;
      shift_out     <= 8'h00;
      addr          <= 8'h00;
      rd_mode       <= 1'b0;
      wr_mode       <= 1'b0;
      cpu_reset_bit <= 1'b0;
      sdo_r         <= 1'b0;
    end else begin
      if (csb_s) armed <= 1'b1;
      if (idle) begin
        // Deselect drops any partial byte; nothing is written.
        bit_cnt <= 3'd0;
        sdo_r   <= 1'b0;
      end else begin
        if (sck_rise && !pass && state != IGNORE) begin
          bit_cnt  <= bit_cnt + 3'd1;
          shift_in <= byte_in;
        end
        if (byte_done) begin
          case (state)
            COMMAND: begin
              rd_mode <= byte_in[6];
              wr_mode <= byte_in[7];
            end
            ADDRESS: begin
              addr      <= byte_in;
              shift_out <= reg_read(byte_in, cpu_reset_bit);
            end
            DATA: begin
              // Next register is read before this write lands; it is never
              // the same address, so read/write stream stays consistent.
              if (wr_mode && addr == 8'h07) cpu_reset_bit <= byte_in[0];
              addr      <= addr_next;
              shift_out <= reg_read(addr_next, cpu_reset_bit);
            end
            default: ;
          endcase
        end
        if (sck_fall && state == DATA && rd_mode) begin
          sdo_r     <= shift_out[7];
          shift_out <= {shift_out[6:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge XCLK or negedge resetn) begin
    if (!resetn) cpu_resetn <= 1'b0;
    else         cpu_resetn <= ~pass & ~cpu_reset_bit;
  end

  // Pass-through paths are deliberately combinational on the raw pins.
  assign flash_csb = pass ? 1'b0 : core_flash_csb;
  assign flash_clk = pass ? SCK  : core_flash_clk;
  assign flash_io0 = pass ? SDI  : core_flash_io0;
  assign SDO       = pass ? flash_io1 : sdo_r;
  assign sdo_enb   = pass ? 1'b0 : ~((state == DATA) && rd_mode);

endmodule

// File: tb/tb_ravenna.sv
// tb/tb_ravenna.sv - directed self-checking bench for ravenna
module tb_ravenna;
  localparam int HALF = 8;

  logic XCLK = 1'b0;
  logic resetn, SCK, CSB, SDI;
  logic SDO, sdo_enb;
  logic core_flash_csb, core_flash_clk, core_flash_io0;
  logic flash_csb, flash_clk, flash_io0;
  logic flash_io1 = 1'b0;
  logic cpu_resetn;

  int errors = 0;
  int checks = 0;

  ravenna dut (
    .XCLK(XCLK), .resetn(resetn), .SCK(SCK), .CSB(CSB), .SDI(SDI),
    .SDO(SDO), .sdo_enb(sdo_enb),
    .core_flash_csb(core_flash_csb), .core_flash_clk(core_flash_clk),
    .core_flash_io0(core_flash_io0),
    .flash_csb(flash_csb), .flash_clk(flash_clk), .flash_io0(flash_io0),
    .flash_io1(flash_io1), .cpu_resetn(cpu_resetn)
  );

  always #5 XCLK = ~XCLK;

  // Flash model: read command 0x03 + 24-bit address, data = addr[7:0]^0xA5
  // inside page 0x1000xx, 0xFF elsewhere.
  logic [31:0] f_cmd = 32'h0;
  int          f_bits = 0;

  always @(negedge flash_csb) f_bits = 0;

  always @(posedge flash_clk) begin
    if (!flash_csb) begin
      if (f_bits < 32) f_cmd = {f_cmd[30:0], flash_io0};
      f_bits++;
    end
  end

  always @(negedge flash_clk) begin : f_out
    logic [23:0] a;
    logic [7:0]  d;
    if (!flash_csb && f_bits >= 32) begin
      a = f_cmd[23:0] + 24'((f_bits - 32) / 8);
      d = (f_cmd[31:24] == 8'h03 && a[23:8] == 16'h1000) ? (a[7:0] ^ 8'hA5) : 8'hFF;
      flash_io1 = d[7 - ((f_bits - 32) % 8)];
    end
  end

  task automatic spi_bits(input logic [7:0] tx, input int n,
                          output logic [7:0] rx, output int enb_ones);
    rx = 8'h00;
    enb_ones = 0;
    for (int i = 7; i > 7 - n; i--) begin
      SDI = tx[i];
      repeat (HALF) @(negedge XCLK);
      rx = {rx[6:0], SDO};
      if (sdo_enb) enb_ones++;
      SCK = 1'b1;
      repeat (HALF) @(negedge XCLK);
      SCK = 1'b0;
    end
  endtask

  task automatic cs_low();
    CSB = 1'b0;
    repeat (HALF) @(negedge XCLK);
  endtask

  task automatic cs_high();
    SCK = 1'b0;
    CSB = 1'b1;
    repeat (HALF) @(negedge XCLK);
  endtask

  task automatic write_reg(input logic [7:0] a, input logic [7:0] d);
    logic [7:0] rx;
    int e;
    cs_low();
    spi_bits(8'h80, 8, rx, e);
    spi_bits(a, 8, rx, e);
    spi_bits(d, 8, rx, e);
    checks++;
    if (e !== 8) begin
      errors++;
      $display("FAIL write_enb addr=%h: sdo_enb high samples %0d, required 8", a, e);
    end
    cs_high();
  endtask

  task automatic test_reset();
    resetn = 1'b0; SCK = 1'b0; CSB = 1'b1; SDI = 1'b0;
    core_flash_csb = 1'b1; core_flash_clk = 1'b0; core_flash_io0 = 1'b1;
    repeat (4) @(negedge XCLK);
    checks++; if (SDO !== 1'b0) begin errors++; $display("FAIL reset_sdo: got %b, required 0", SDO); end
    checks++; if (sdo_enb !== 1'b1) begin errors++; $display("FAIL reset_sdo_enb: got %b, required 1", sdo_enb); end
    checks++; if (cpu_resetn !== 1'b0) begin errors++; $display("FAIL reset_cpu_resetn: got %b, required 0", cpu_resetn); end
    checks++;
    if ({flash_csb, flash_clk, flash_io0} !== 3'b101) begin
      errors++; $display("FAIL reset_flash_mux: got %b, required 101", {flash_csb, flash_clk, flash_io0});
    end
    resetn = 1'b1;
    repeat (HALF) @(negedge XCLK);
    checks++; if (cpu_resetn !== 1'b1) begin errors++; $display("FAIL reset_release_cpu: got %b, required 1", cpu_resetn); end
    core_flash_io0 = 1'b0;
  endtask

  task automatic test_read_prod();
    logic [7:0] rx;
    int e0, e1, e2;
    cs_low();
    spi_bits(8'h40, 8, rx, e0);
    spi_bits(8'h03, 8, rx, e1);
    spi_bits(8'h00, 8, rx, e2);
    checks++; if (rx !== 8'h03) begin errors++; $display("FAIL read_prod: got %h, required 03", rx); end
    checks++;
    if (e0 !== 8 || e1 !== 8 || e2 !== 0) begin
      errors++; $display("FAIL read_prod_enb: high samples cmd=%0d addr=%0d data=%0d, required 8 8 0", e0, e1, e2);
    end
    cs_high();
    checks++; if (sdo_enb !== 1'b1) begin errors++; $display("FAIL read_prod_enb_idle: got %b, required 1", sdo_enb); end
  endtask

  task automatic test_read_stream();
    logic [7:0] rx;
    logic [7:0] exp_a [2] = '{8'h04, 8'h56};
    logic [7:0] exp_b [3] = '{8'h00, 8'h00, 8'h04};
    int e;
    cs_low();
    spi_bits(8'h40, 8, rx, e);
    spi_bits(8'h01, 8, rx, e);
    for (int i = 0; i < 2; i++) begin
      spi_bits(8'h00, 8, rx, e);
      checks++; if (rx !== exp_a[i]) begin errors++; $display("FAIL stream_01[%0d]: got %h, required %h", i, rx, exp_a[i]); end
    end
    cs_high();
    cs_low();
    spi_bits(8'h40, 8, rx, e);
    spi_bits(8'hFF, 8, rx, e);
    for (int i = 0; i < 3; i++) begin
      spi_bits(8'h00, 8, rx, e);
      checks++; if (rx !== exp_b[i]) begin errors++; $display("FAIL stream_wrap[%0d]: got %h, required %h", i, rx, exp_b[i]); end
    end
    cs_high();
  endtask

  task automatic test_cpu_reset();
    logic [7:0] rx;
    int e;
    write_reg(8'h07, 8'h01);
    checks++; if (cpu_resetn !== 1'b0) begin errors++; $display("FAIL cpu_reset_set: got %b, required 0", cpu_resetn); end
    cs_low();
    spi_bits(8'h40, 8, rx, e);
    spi_bits(8'h07, 8, rx, e);
    spi_bits(8'h00, 8, rx, e);
    checks++; if (rx !== 8'h01) begin errors++; $display("FAIL cpu_reset_read: got %h, required 01", rx); end
    cs_high();
    write_reg(8'h07, 8'h00);
    checks++; if (cpu_resetn !== 1'b1) begin errors++; $display("FAIL cpu_reset_clear: got %b, required 1", cpu_resetn); end
  endtask

  task automatic test_read_write();
    logic [7:0] rx;
    int e;
    cs_low();
    spi_bits(8'hC0, 8, rx, e);
    spi_bits(8'h07, 8, rx, e);
    spi_bits(8'hFF, 8, rx, e);
    checks++; if (rx !== 8'h00) begin errors++; $display("FAIL rw_old_value: got %h, required 00", rx); end
    cs_high();
    checks++; if (cpu_resetn !== 1'b0) begin errors++; $display("FAIL rw_cpu_reset: got %b, required 0", cpu_resetn); end
    cs_low();
    spi_bits(8'hC0, 8, rx, e);
    spi_bits(8'h07, 8, rx, e);
    spi_bits(8'h00, 8, rx, e);
    checks++; if (rx !== 8'h01) begin errors++; $display("FAIL rw_second_value: got %h, required 01", rx); end
    cs_high();
    checks++; if (cpu_resetn !== 1'b1) begin errors++; $display("FAIL rw_cpu_release: got %b, required 1", cpu_resetn); end
  endtask

  task automatic test_ignore_and_partial();
    logic [7:0] rx;
    int e0, e1, e2;
    cs_low();
    spi_bits(8'h11, 8, rx, e0);
    spi_bits(8'h07, 8, rx, e1);
    spi_bits(8'h01, 8, rx, e2);
    checks++;
    if (e0 !== 8 || e1 !== 8 || e2 !== 8) begin
      errors++; $display("FAIL ignore_enb: high samples %0d %0d %0d, required 8 8 8", e0, e1, e2);
    end
    cs_high();
    checks++; if (cpu_resetn !== 1'b1) begin errors++; $display("FAIL ignore_no_write: cpu_resetn %b, required 1", cpu_resetn); end
    write_reg(8'h07, 8'h01);
    cs_low();
    spi_bits(8'h80, 8, rx, e0);
    spi_bits(8'h07, 8, rx, e0);
    spi_bits(8'h00, 4, rx, e0);
    cs_high();
    checks++; if (cpu_resetn !== 1'b0) begin errors++; $display("FAIL partial_cpu: got %b, required 0", cpu_resetn); end
    cs_low();
    spi_bits(8'h40, 8, rx, e0);
    spi_bits(8'h07, 8, rx, e0);
    spi_bits(8'h00, 8, rx, e0);
    checks++; if (rx !== 8'h01) begin errors++; $display("FAIL partial_reg: got %h, required 01", rx); end
    cs_high();
    write_reg(8'h07, 8'h00);
  endtask

  task automatic test_passthru();
    logic [7:0] rx;
    logic [7:0] exp [8] = '{8'hA5, 8'hA4, 8'hA7, 8'hA6, 8'hA1, 8'hA0, 8'hA3, 8'hA2};
    int e;
    core_flash_clk = 1'b1;
    @(negedge XCLK);
    cs_low();
    spi_bits(8'hC4, 8, rx, e);
    repeat (4) @(negedge XCLK);
    checks++; if (flash_csb !== 1'b0) begin errors++; $display("FAIL pt_flash_csb: got %b, required 0", flash_csb); end
    checks++; if (cpu_resetn !== 1'b0) begin errors++; $display("FAIL pt_cpu_resetn: got %b, required 0", cpu_resetn); end
    SDI = 1'b1; #1;
    checks++; if (flash_io0 !== 1'b1) begin errors++; $display("FAIL pt_io0: got %b, required 1", flash_io0); end
    spi_bits(8'h03, 8, rx, e);
    spi_bits(8'h10, 8, rx, e);
    spi_bits(8'h00, 8, rx, e);
    spi_bits(8'h00, 8, rx, e);
    for (int i = 0; i < 8; i++) begin
      spi_bits(8'h00, 8, rx, e);
      checks++;
      if (rx !== exp[i] || e !== 0) begin
        errors++; $display("FAIL pt_data[%0d]: got %h enb_high=%0d, required %h enb_high=0", i, rx, e, exp[i]);
      end
    end
    core_flash_clk = 1'b0;
    cs_high();
    checks++; if (flash_csb !== 1'b1) begin errors++; $display("FAIL pt_exit_csb: got %b, required 1", flash_csb); end
    checks++; if (cpu_resetn !== 1'b1) begin errors++; $display("FAIL pt_exit_cpu: got %b, required 1", cpu_resetn); end
    core_flash_csb = 1'b0; core_flash_clk = 1'b1; core_flash_io0 = 1'b1; #1;
    checks++;
    if ({flash_csb, flash_clk, flash_io0} !== 3'b011) begin
      errors++; $display("FAIL pt_exit_mux: got %b, required 011", {flash_csb, flash_clk, flash_io0});
    end
    core_flash_csb = 1'b1; core_flash_clk = 1'b0; core_flash_io0 = 1'b0;
    @(negedge XCLK);
  endtask

  task automatic test_reset_mid();
    logic [7:0] rx;
    int e;
    write_reg(8'h07, 8'h01);
    cs_low();
    spi_bits(8'h40, 8, rx, e);
    spi_bits(8'h01, 8, rx, e);
    spi_bits(8'h00, 8, rx, e);
    checks++; if (rx !== 8'h04) begin errors++; $display("FAIL midrst_pre: got %h, required 04", rx); end
    spi_bits(8'h00, 3, rx, e);
    resetn = 1'b0;
    repeat (3) @(negedge XCLK);
    checks++;
    if (SDO !== 1'b0 || sdo_enb !== 1'b1 || cpu_resetn !== 1'b0) begin
      errors++; $display("FAIL midrst_outputs: SDO=%b sdo_enb=%b cpu_resetn=%b, required 0 1 0", SDO, sdo_enb, cpu_resetn);
    end
    resetn = 1'b1;
    repeat (4) @(negedge XCLK);
    checks++; if (cpu_resetn !== 1'b1) begin errors++; $display("FAIL midrst_cpu_reset_cleared: got %b, required 1", cpu_resetn); end
    spi_bits(8'h40, 8, rx, e);
    spi_bits(8'h03, 8, rx, e);
    spi_bits(8'h00, 8, rx, e);
    checks++;
    if (rx !== 8'h00 || e !== 8) begin
      errors++; $display("FAIL midrst_wait_csb: got %h enb_high=%0d, required 00 enb_high=8", rx, e);
    end
    cs_high();
    cs_low();
    spi_bits(8'h40, 8, rx, e);
    spi_bits(8'h03, 8, rx, e);
    spi_bits(8'h00, 8, rx, e);
    checks++; if (rx !== 8'h03) begin errors++; $display("FAIL midrst_after: got %h, required 03", rx); end
    cs_high();
  endtask

  initial begin
    test_reset();
    test_read_prod();
    test_read_stream();
    test_cpu_reset();
    test_read_write();
    test_ignore_and_partial();
    test_passthru();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
